scpad_sram_arbiter: RTL and testbench

Shares the scratchpad SRAM read port and write port among the three requesters: the frontend VC path, the frontend SA path and the backend. It grants one read and one write per cycle using independent round-robin arbiters and registers the winners onto `sram_read_req` / `sram_write_req`. It tracks outstanding requests in in-order tag FIFOs and routes each `sram_read_res` / `sram_write_res` back to its originator by `int_id`. It sits between the frontend/backend request generators and the SRAM controller, and drives `sram_busy`.

---
 rtl/scpad_types_pkg.sv | 58 +++++
 rtl/scpad_tag_fifo.sv | 76 +++++++
 rtl/scpad_sram_arbiter.sv | 253 +++++++++++++++++++++++++
 tb/tb_scpad_sram_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scpad_types_pkg.sv
// -----------------------------------------------------------------------------
// scpad_types_pkg
// Shared types for the scratchpad SRAM path: requester index / int_id
// encoding, SRAM request and response structs used by the arbiter and the
// crossbars, and the default number of outstanding tags per channel.
// -----------------------------------------------------------------------------
package scpad_types_pkg;

    localparam int SCPAD_TAG_DEPTH = 4;
    localparam int SRAM_ADDR_W     = 16;
    localparam int SRAM_DATA_W     = 32;
    localparam int SCPAD_NUM_REQ   = 3;

    // Requester indices double as the int_id carried to the SRAM controller.
    typedef enum logic [1:0] {
        INT_ID_VC  = 2'b00,
        INT_ID_SA  = 2'b01,
        INT_ID_BE  = 2'b10,
        INT_ID_BAD = 2'b11
    } int_id_e;

    typedef struct packed {
        logic                   valid;
        logic [1:0]             int_id;
        logic [SRAM_ADDR_W-1:0] addr;
    } sram_r_req_t;

    typedef struct packed {
        logic                   valid;
        logic [1:0]             int_id;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
    } sram_w_req_t;

    typedef struct packed {
        logic                   valid;
        logic [1:0]             int_id;
        logic [SRAM_DATA_W-1:0] rdata;
    } sram_r_res_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] int_id;
    } sram_w_res_t;

    // One-hot grant vector for a requester index; index 3 means "no winner".
    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/scpad_tag_fifo.sv
// -----------------------------------------------------------------------------
// scpad_tag_fifo
// In-order FIFO of requester tags for one SRAM channel.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_push, i_push_data   enqueue a tag (accepted when not full, or when a pop
//                         happens in the same cycle)
//   i_pop                 dequeue the head (ignored when empty)
//   o_head                oldest tag
//   o_full, o_empty       occupancy flags
// -----------------------------------------------------------------------------
module scpad_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == {CW{1'b0}});
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage; cleared on reset so the head never carries stale state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/scpad_sram_arbiter.sv
// -----------------------------------------------------------------------------
// scpad_sram_arbiter
// Shares the scratchpad SRAM read and write ports among the VC path, the SA
// path and the backend. Each channel has its own round-robin arbiter, output
// register and in-order tag FIFO used to route responses back by int_id.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   {vc,sa,backend}_sram_{r,w}_banks_req   requests (hold until granted)
//   {vc,sa,backend}_sram_{r,w}_banks_res   routed read data / write acks
//   r_gnt, w_gnt                      one-hot grants (bit0 VC, bit1 SA, bit2 BE)
//   sram_read_req, sram_write_req     registered requests to the SRAM controller
//   sram_read_res, sram_write_res     responses from the SRAM controller
//   sram_busy                         backpressure indication
//   tag_err                           sticky response/tag mismatch flag
// -----------------------------------------------------------------------------
module scpad_sram_arbiter
    import scpad_types_pkg::*;
#(
    parameter int TAG_DEPTH = SCPAD_TAG_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  sram_r_req_t vc_sram_r_banks_req,
    input  sram_r_req_t sa_sram_r_banks_req,
    input  sram_r_req_t backend_sram_r_banks_req,
    input  sram_w_req_t vc_sram_w_banks_req,
    input  sram_w_req_t sa_sram_w_banks_req,
    input  sram_w_req_t backend_sram_w_banks_req,
    output sram_r_res_t vc_sram_r_banks_res,
    output sram_r_res_t sa_sram_r_banks_res,
    output sram_r_res_t backend_sram_r_banks_res,
    output sram_w_res_t vc_sram_w_banks_res,
    output sram_w_res_t sa_sram_w_banks_res,
    output sram_w_res_t backend_sram_w_banks_res,
    output logic [2:0]  r_gnt,
    output logic [2:0]  w_gnt,
    output sram_r_req_t sram_read_req,
    output sram_w_req_t sram_write_req,
    input  sram_r_res_t sram_read_res,
    input  sram_w_res_t sram_write_res,
    output logic        sram_busy,
    output logic        tag_err
);

    // Round-robin pick: search starts just after the last winner.
    // Returns the winner index, or 3 when nobody requests.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] pick;
        pick = 2'd3;
        case (last)
            2'd0: begin
                if (req[1])      pick = 2'd1;
                else if (req[2]) pick = 2'd2;
                else if (req[0]) pick = 2'd0;
                else             pick = 2'd3;
            end
            2'd1: begin
                if (req[2])      pick = 2'd2;
                else if (req[0]) pick = 2'd0;
                else if (req[1]) pick = 2'd1;
                else             pick = 2'd3;
            end
            default: begin
                if (req[0])      pick = 2'd0;
                else if (req[1]) pick = 2'd1;
                else if (req[2]) pick = 2'd2;
                else             pick = 2'd3;
            end
        endcase
        return pick;
    endfunction

    logic [1:0]  r_r_last;
    logic [1:0]  r_w_last;
    logic [2:0]  w_r_valids;
    logic [2:0]  w_w_valids;
    logic [1:0]  w_r_pick;
    logic [1:0]  w_w_pick;
    int_id_e     w_r_win;
    int_id_e     w_w_win;
    logic        w_r_fire;
    logic        w_w_fire;
    logic        w_r_pop;
    logic        w_w_pop;
    logic        w_r_err;
    logic        w_w_err;
    logic [1:0]  w_rf_head;
    logic [1:0]  w_wf_head;
    logic        w_rf_full;
    logic        w_rf_empty;
    logic        w_wf_full;
    logic        w_wf_empty;
    sram_r_req_t w_r_win_req;
    sram_w_req_t w_w_win_req;
    sram_r_res_t w_r_route;
    sram_w_res_t w_w_route;

    assign w_r_valids = {backend_sram_r_banks_req.valid, sa_sram_r_banks_req.valid,
                         vc_sram_r_banks_req.valid};
    assign w_w_valids = {backend_sram_w_banks_req.valid, sa_sram_w_banks_req.valid,
                         vc_sram_w_banks_req.valid};

    assign w_r_pick = rr_pick(w_r_valids, r_r_last);
    assign w_w_pick = rr_pick(w_w_valids, r_w_last);
    assign w_r_win  = int_id_e'(w_r_pick);
    assign w_w_win  = int_id_e'(w_w_pick);

    // A response pops the head even on an id mismatch: routing follows the head.
    assign w_r_pop  = !rst && sram_read_res.valid  && !w_rf_empty;
    assign w_w_pop  = !rst && sram_write_res.valid && !w_wf_empty;

    // A full FIFO can still grant when its head retires this cycle.
    assign w_r_fire = !rst && (|w_r_valids) && (!w_rf_full || w_r_pop);
    assign w_w_fire = !rst && (|w_w_valids) && (!w_wf_full || w_w_pop);

    assign r_gnt = w_r_fire ? idx_to_onehot(w_r_pick) : 3'b000;
    assign w_gnt = w_w_fire ? idx_to_onehot(w_w_pick) : 3'b000;

    assign w_r_err = sram_read_res.valid &&
                     (w_rf_empty || (w_rf_head != sram_read_res.int_id) ||
                      (sram_read_res.int_id == INT_ID_BAD));
    assign w_w_err = sram_write_res.valid &&
                     (w_wf_empty || (w_wf_head != sram_write_res.int_id) ||
                      (sram_write_res.int_id == INT_ID_BAD));

    assign sram_busy = !rst && ((|(w_r_valids & ~r_gnt)) || (|(w_w_valids & ~w_gnt)) ||
                                w_rf_full || w_wf_full);

    // Read winner payload with int_id replaced by the winner's own encoding.
    always_comb begin
        w_r_win_req = '0;
        case (w_r_win)
            INT_ID_VC: w_r_win_req = vc_sram_r_banks_req;
            INT_ID_SA: w_r_win_req = sa_sram_r_banks_req;
            INT_ID_BE: w_r_win_req = backend_sram_r_banks_req;
            default:   w_r_win_req = '0;
        endcase
        w_r_win_req.int_id = w_r_win;
    end

    // Write winner payload with int_id replaced by the winner's own encoding.
    always_comb begin
        w_w_win_req = '0;
        case (w_w_win)
            INT_ID_VC: w_w_win_req = vc_sram_w_banks_req;
            INT_ID_SA: w_w_win_req = sa_sram_w_banks_req;
            INT_ID_BE: w_w_win_req = backend_sram_w_banks_req;
            default:   w_w_win_req = '0;
        endcase
        w_w_win_req.int_id = w_w_win;
    end

    // Read channel output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_read_req <= '0;
            r_r_last      <= 2'd2;
        end else if (w_r_fire) begin
            sram_read_req <= w_r_win_req;
            r_r_last      <= w_r_pick;
        end else begin
            sram_read_req <= '0;
        end
    end

    // Write channel output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_write_req <= '0;
            r_w_last       <= 2'd2;
        end else if (w_w_fire) begin
            sram_write_req <= w_w_win_req;
            r_w_last       <= w_w_pick;
        end else begin
            sram_write_req <= '0;
        end
    end

    // Sticky tag error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_err <= 1'b0;
        end else if (w_r_err || w_w_err) begin
            tag_err <= 1'b1;
        end else begin
            tag_err <= tag_err;
        end
    end

    scpad_tag_fifo #(.DEPTH(TAG_DEPTH), .WIDTH(2)) u_rd_tags (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_push      (w_r_fire),
        .i_push_data (w_r_pick),
        .i_pop       (w_r_pop),
        .o_head      (w_rf_head),
        .o_full      (w_rf_full),
        .o_empty     (w_rf_empty)
    );

    scpad_tag_fifo #(.DEPTH(TAG_DEPTH), .WIDTH(2)) u_wr_tags (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_push      (w_w_fire),
        .i_push_data (w_w_pick),
        .i_pop       (w_w_pop),
        .o_head      (w_wf_head),
        .o_full      (w_wf_full),
        .o_empty     (w_wf_empty)
    );

    // Read data goes to the requester named by the FIFO head.
    always_comb begin
        vc_sram_r_banks_res      = '0;
        sa_sram_r_banks_res      = '0;
        backend_sram_r_banks_res = '0;
        w_r_route                = '0;
        w_r_route.valid          = 1'b1;
        w_r_route.int_id         = w_rf_head;
        w_r_route.rdata          = sram_read_res.rdata;
        if (w_r_pop) begin
            case (w_rf_head)
                2'b00:   vc_sram_r_banks_res      = w_r_route;
                2'b01:   sa_sram_r_banks_res      = w_r_route;
                2'b10:   backend_sram_r_banks_res = w_r_route;
                default: vc_sram_r_banks_res      = '0;
            endcase
        end else begin
            vc_sram_r_banks_res = '0;
        end
    end

    // Write acks go to the requester named by the FIFO head.
    always_comb begin
        vc_sram_w_banks_res      = '0;
        sa_sram_w_banks_res      = '0;
        backend_sram_w_banks_res = '0;
        w_w_route                = '0;
        w_w_route.valid          = 1'b1;
        w_w_route.int_id         = w_wf_head;
        if (w_w_pop) begin
            case (w_wf_head)
                2'b00:   vc_sram_w_banks_res      = w_w_route;
                2'b01:   sa_sram_w_banks_res      = w_w_route;
                2'b10:   backend_sram_w_banks_res = w_w_route;
                default: vc_sram_w_banks_res      = '0;
            endcase
        end else begin
            vc_sram_w_banks_res = '0;
        end
    end

endmodule

// File: tb/tb_scpad_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_scpad_sram_arbiter
// Self-checking bench: directed scenarios followed by randomized traffic, all
// compared against a queue-based reference model of the arbiter.
// -----------------------------------------------------------------------------
module tb_scpad_sram_arbiter;
    import scpad_types_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    sram_r_req_t vc_r, sa_r, be_r;
    sram_w_req_t vc_w, sa_w, be_w;
    sram_r_res_t vc_rr, sa_rr, be_rr;
    sram_w_res_t vc_wr, sa_wr, be_wr;
    logic [2:0]  r_gnt, w_gnt;
    sram_r_req_t sram_read_req;
    sram_w_req_t sram_write_req;
    sram_r_res_t rd_res;
    sram_w_res_t wr_res;
    logic        sram_busy, tag_err;

    scpad_sram_arbiter #(.TAG_DEPTH(DEPTH)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .vc_sram_r_banks_req      (vc_r),
        .sa_sram_r_banks_req      (sa_r),
        .backend_sram_r_banks_req (be_r),
        .vc_sram_w_banks_req      (vc_w),
        .sa_sram_w_banks_req      (sa_w),
        .backend_sram_w_banks_req (be_w),
        .vc_sram_r_banks_res      (vc_rr),
        .sa_sram_r_banks_res      (sa_rr),
        .backend_sram_r_banks_res (be_rr),
        .vc_sram_w_banks_res      (vc_wr),
        .sa_sram_w_banks_res      (sa_wr),
        .backend_sram_w_banks_res (be_wr),
        .r_gnt                    (r_gnt),
        .w_gnt                    (w_gnt),
        .sram_read_req            (sram_read_req),
        .sram_write_req           (sram_write_req),
        .sram_read_res            (rd_res),
        .sram_write_res           (wr_res),
        .sram_busy                (sram_busy),
        .tag_err                  (tag_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state: outstanding tags as plain queues of requester ids.
    int          m_rq[$];
    int          m_wq[$];
    int          m_r_last = 2;
    int          m_w_last = 2;
    sram_r_req_t m_rreq   = '0;
    sram_w_req_t m_wreq   = '0;
    logic        m_tag_err = 1'b0;
    int          m_rwin = -1;
    int          m_wwin = -1;

    // Observed combinational outputs of the last step (for directed checks).
    logic [2:0]  obs_rgnt, obs_wgnt;
    logic        obs_busy;
    sram_r_res_t obs_rres[3];
    sram_w_res_t obs_wres[3];

    function automatic int rr_next(input logic [2:0] v, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (v[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    task automatic idle();
        vc_r = '0; sa_r = '0; be_r = '0;
        vc_w = '0; sa_w = '0; be_w = '0;
        rd_res = '0; wr_res = '0;
    endtask

    // One clock cycle: predict, compare combinational outputs, clock, compare registers.
    task automatic step();
        sram_r_req_t ri[3];
        sram_w_req_t wi[3];
        sram_r_res_t er[3];
        sram_w_res_t ew[3];
        logic [2:0]  rv, wv, egr, egw;
        logic        rpop, wpop, rerr, werr, rfire, wfire, ebusy;
        int          rwin, wwin;
        ri[0] = vc_r; ri[1] = sa_r; ri[2] = be_r;
        wi[0] = vc_w; wi[1] = sa_w; wi[2] = be_w;
        rv = {ri[2].valid, ri[1].valid, ri[0].valid};
        wv = {wi[2].valid, wi[1].valid, wi[0].valid};
        for (int i = 0; i < 3; i++) begin er[i] = '0; ew[i] = '0; end
        egr = 3'b000; egw = 3'b000; ebusy = 1'b0;
        rpop = 1'b0; wpop = 1'b0; rerr = 1'b0; werr = 1'b0; rfire = 1'b0; wfire = 1'b0;
        rwin = rr_next(rv, m_r_last);
        wwin = rr_next(wv, m_w_last);
        if (!rst) begin
            rpop = rd_res.valid && (m_rq.size() > 0);
            wpop = wr_res.valid && (m_wq.size() > 0);
            rerr = rd_res.valid && ((m_rq.size() == 0) || (rd_res.int_id == 2'b11) ||
                                    (int'(rd_res.int_id) != m_rq[0]));
            werr = wr_res.valid && ((m_wq.size() == 0) || (wr_res.int_id == 2'b11) ||
                                    (int'(wr_res.int_id) != m_wq[0]));
            rfire = (rwin >= 0) && ((m_rq.size() < DEPTH) || rpop);
            wfire = (wwin >= 0) && ((m_wq.size() < DEPTH) || wpop);
            if (rfire) egr = 3'b001 << rwin;
            if (wfire) egw = 3'b001 << wwin;
            if (rpop) begin
                er[m_rq[0]].valid  = 1'b1;
                er[m_rq[0]].int_id = 2'(m_rq[0]);
                er[m_rq[0]].rdata  = rd_res.rdata;
            end
            if (wpop) begin
                ew[m_wq[0]].valid  = 1'b1;
                ew[m_wq[0]].int_id = 2'(m_wq[0]);
            end
            ebusy = ((rv & ~egr) != 3'b000) || ((wv & ~egw) != 3'b000) ||
                    (m_rq.size() == DEPTH) || (m_wq.size() == DEPTH);
        end
        #1;
        obs_rgnt = r_gnt; obs_wgnt = w_gnt; obs_busy = sram_busy;
        obs_rres[0] = vc_rr; obs_rres[1] = sa_rr; obs_rres[2] = be_rr;
        obs_wres[0] = vc_wr; obs_wres[1] = sa_wr; obs_wres[2] = be_wr;
        check_val("r_gnt", 64'(r_gnt), 64'(egr));
        check_val("w_gnt", 64'(w_gnt), 64'(egw));
        check_val("sram_busy", 64'(sram_busy), 64'(ebusy));
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("r_res%0d", i), 64'(obs_rres[i]), 64'(er[i]));
            check_val($sformatf("w_res%0d", i), 64'(obs_wres[i]), 64'(ew[i]));
        end
        @(posedge clk);
        if (rst) begin
            m_rq.delete(); m_wq.delete();
            m_r_last = 2; m_w_last = 2;
            m_rreq = '0; m_wreq = '0; m_tag_err = 1'b0;
            m_rwin = -1; m_wwin = -1;
        end else begin
            if (rpop) void'(m_rq.pop_front());
            if (wpop) void'(m_wq.pop_front());
            if (rfire) begin
                m_rq.push_back(rwin); m_r_last = rwin;
                m_rreq = ri[rwin]; m_rreq.int_id = 2'(rwin);
            end else begin
                m_rreq = '0;
            end
            if (wfire) begin
                m_wq.push_back(wwin); m_w_last = wwin;
                m_wreq = wi[wwin]; m_wreq.int_id = 2'(wwin);
            end else begin
                m_wreq = '0;
            end
            m_rwin = rfire ? rwin : -1;
            m_wwin = wfire ? wwin : -1;
            m_tag_err = m_tag_err | rerr | werr;
        end
        #1;
        check_val("sram_read_req", 64'(sram_read_req), 64'(m_rreq));
        check_val("sram_write_req", 64'(sram_write_req), 64'(m_wreq));
        check_val("tag_err", 64'(tag_err), 64'(m_tag_err));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    function automatic sram_r_req_t mk_r(input logic [15:0] a);
        sram_r_req_t q;
        q.valid = 1'b1; q.int_id = 2'b11; q.addr = a;
        return q;
    endfunction

    function automatic sram_w_req_t mk_w(input logic [15:0] a, input logic [31:0] d);
        sram_w_req_t q;
        q.valid = 1'b1; q.int_id = 2'b11; q.addr = a; q.wdata = d;
        return q;
    endfunction

    logic [2:0]  fair_seq [6];
    logic [2:0]  fair_exp [6];
    bit          r_pend[3], w_pend[3];
    sram_r_req_t r_pay[3];
    sram_w_req_t w_pay[3];

    initial begin
        fair_exp[0] = 3'b001; fair_exp[1] = 3'b010; fair_exp[2] = 3'b100;
        fair_exp[3] = 3'b001; fair_exp[4] = 3'b010; fair_exp[5] = 3'b100;

        // Reset state
        rst = 1'b1;
        idle();
        step();
        step();
        check_val("rst_read_req", 64'(sram_read_req), 64'd0);
        check_val("rst_write_req", 64'(sram_write_req), 64'd0);
        check_val("rst_tag_err", 64'(tag_err), 64'd0);
        rst = 1'b0;

        // Single VC read
        vc_r = mk_r(16'h0040);
        step();
        check_val("vc_read_gnt", 64'(obs_rgnt), 64'(3'b001));
        idle();
        check_val("vc_read_req_valid", 64'(sram_read_req.valid), 64'd1);
        check_val("vc_read_req_id", 64'(sram_read_req.int_id), 64'd0);
        check_val("vc_read_req_addr", 64'(sram_read_req.addr), 64'h40);
        rd_res.valid = 1'b1; rd_res.int_id = 2'b00; rd_res.rdata = 32'hA5A5_A5A5;
        step();
        idle();
        check_val("vc_res_valid", 64'(obs_rres[0].valid), 64'd1);
        check_val("vc_res_data", 64'(obs_rres[0].rdata), 64'hA5A5_A5A5);
        check_val("vc_res_sa_quiet", 64'(obs_rres[1].valid), 64'd0);
        check_val("vc_res_be_quiet", 64'(obs_rres[2].valid), 64'd0);

        // Fairness: all three reads held, head retired every cycle
        do_reset();
        for (int c = 0; c < 6; c++) begin
            vc_r = mk_r(16'h0100); sa_r = mk_r(16'h0200); be_r = mk_r(16'h0300);
            rd_res = '0;
            if (m_rq.size() > 0) begin
                rd_res.valid = 1'b1; rd_res.int_id = 2'(m_rq[0]); rd_res.rdata = 32'(c);
            end
            step();
            fair_seq[c] = obs_rgnt;
        end
        for (int c = 0; c < 6; c++) begin
            check_val($sformatf("fair_gnt%0d", c), 64'(fair_seq[c]), 64'(fair_exp[c]));
        end

        // Backpressure: backend streams reads without responses
        do_reset();
        be_r = mk_r(16'h0777);
        for (int c = 0; c < 4; c++) begin
            step();
            check_val($sformatf("bp_gnt%0d", c), 64'(obs_rgnt), 64'(3'b100));
        end
        step();
        check_val("bp_full_gnt", 64'(obs_rgnt), 64'd0);
        check_val("bp_full_busy", 64'(obs_busy), 64'd1);
        rd_res.valid = 1'b1; rd_res.int_id = 2'b10; rd_res.rdata = 32'h1234_5678;
        step();
        check_val("bp_pop_gnt", 64'(obs_rgnt), 64'(3'b100));
        check_val("bp_pop_route", 64'(obs_rres[2].valid), 64'd1);
        be_r = '0;
        for (int c = 0; c < DEPTH; c++) begin
            rd_res.valid = 1'b1; rd_res.int_id = 2'b10; rd_res.rdata = 32'(c + 100);
            step();
        end
        idle();
        step();
        check_val("bp_drained_busy", 64'(obs_busy), 64'd0);

        // Concurrent channels
        do_reset();
        vc_w = mk_w(16'h0010, 32'hDEAD_BEEF);
        sa_r = mk_r(16'h0020);
        step();
        check_val("conc_rgnt", 64'(obs_rgnt), 64'(3'b010));
        check_val("conc_wgnt", 64'(obs_wgnt), 64'(3'b001));
        idle();
        rd_res.valid = 1'b1; rd_res.int_id = 2'b01; rd_res.rdata = 32'h0BAD_F00D;
        wr_res.valid = 1'b1; wr_res.int_id = 2'b00;
        step();
        idle();
        check_val("conc_sa_rres", 64'(obs_rres[1].valid), 64'd1);
        check_val("conc_vc_rres", 64'(obs_rres[0].valid), 64'd0);
        check_val("conc_be_rres", 64'(obs_rres[2].valid), 64'd0);
        check_val("conc_vc_wres", 64'(obs_wres[0].valid), 64'd1);
        check_val("conc_sa_wres", 64'(obs_wres[1].valid), 64'd0);
        check_val("conc_be_wres", 64'(obs_wres[2].valid), 64'd0);

        // Tag errors: empty FIFO, then id mismatch
        do_reset();
        rd_res.valid = 1'b1; rd_res.int_id = 2'b00; rd_res.rdata = 32'h1;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("err_empty_res%0d", i), 64'(obs_rres[i].valid), 64'd0);
        end
        check_val("err_empty_flag", 64'(tag_err), 64'd1);
        do_reset();
        be_r = mk_r(16'h0abc);
        step();
        idle();
        rd_res.valid = 1'b1; rd_res.int_id = 2'b01; rd_res.rdata = 32'h2;
        step();
        idle();
        check_val("err_mis_be", 64'(obs_rres[2].valid), 64'd1);
        check_val("err_mis_sa", 64'(obs_rres[1].valid), 64'd0);
        check_val("err_mis_flag", 64'(tag_err), 64'd1);

        // Reset mid-operation with three reads outstanding
        do_reset();
        for (int c = 0; c < 3; c++) begin
            vc_r = mk_r(16'h0001); sa_r = mk_r(16'h0002); be_r = mk_r(16'h0003);
            step();
        end
        rst = 1'b1;
        step();
        check_val("midrst_gnt", 64'(obs_rgnt), 64'd0);
        check_val("midrst_req", 64'(sram_read_req), 64'd0);
        check_val("midrst_tag_err", 64'(tag_err), 64'd0);
        rst = 1'b0;
        step();
        check_val("midrst_first_gnt", 64'(obs_rgnt), 64'(3'b001));
        idle();
        step();

        // Randomized traffic: clean responses first, then error and reset injection
        do_reset();
        for (int i = 0; i < 3; i++) begin r_pend[i] = 1'b0; w_pend[i] = 1'b0; end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            bit errs;
            errs = (cyc >= 1500);
            for (int i = 0; i < 3; i++) begin
                if (!r_pend[i] && ($urandom_range(0, 2) == 0)) begin
                    r_pend[i] = 1'b1;
                    r_pay[i].valid = 1'b1;
                    r_pay[i].int_id = 2'($urandom_range(0, 3));
                    r_pay[i].addr = 16'($urandom);
                end
                if (!w_pend[i] && ($urandom_range(0, 2) == 0)) begin
                    w_pend[i] = 1'b1;
                    w_pay[i].valid = 1'b1;
                    w_pay[i].int_id = 2'($urandom_range(0, 3));
                    w_pay[i].addr = 16'($urandom);
                    w_pay[i].wdata = $urandom;
                end
            end
            if (r_pend[0]) vc_r = r_pay[0]; else vc_r = '0;
            if (r_pend[1]) sa_r = r_pay[1]; else sa_r = '0;
            if (r_pend[2]) be_r = r_pay[2]; else be_r = '0;
            if (w_pend[0]) vc_w = w_pay[0]; else vc_w = '0;
            if (w_pend[1]) sa_w = w_pay[1]; else sa_w = '0;
            if (w_pend[2]) be_w = w_pay[2]; else be_w = '0;
            rd_res = '0;
            wr_res = '0;
            if ((m_rq.size() > 0) && ($urandom_range(0, 9) < 4)) begin
                rd_res.valid = 1'b1; rd_res.int_id = 2'(m_rq[0]); rd_res.rdata = $urandom;
            end
            if ((m_wq.size() > 0) && ($urandom_range(0, 9) < 4)) begin
                wr_res.valid = 1'b1; wr_res.int_id = 2'(m_wq[0]);
            end
            if (errs && ($urandom_range(0, 9) == 0)) begin
                rd_res.valid = 1'b1; rd_res.int_id = 2'($urandom_range(0, 3));
                rd_res.rdata = $urandom;
            end
            if (errs && ($urandom_range(0, 9) == 0)) begin
                wr_res.valid = 1'b1; wr_res.int_id = 2'($urandom_range(0, 3));
            end
            rst = errs && ($urandom_range(0, 99) == 0);
            step();
            for (int i = 0; i < 3; i++) begin
                if (m_rwin == i) r_pend[i] = 1'b0;
                if (m_wwin == i) w_pend[i] = 1'b0;
            end
        end
        rst = 1'b0;
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
